multicycle_alu: RTL

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It accepts one operation at a time over a valid/ready input channel and executes it. Add, subtract and the shifts complete in one cycle. Multiply, square and divide run iteratively over WIDTH cycles. The result is held on a valid/ready output channel with carry, zero and divide-by-zero flags, plus a high word that carries the upper product or the remainder. It sits between the processor's register file/sequencer and writeback.

---
 rtl/multicycle_alu.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU. Add, sub, the shifts and the reserved
// selects finish in one cycle. Mul, div and the squares run one shift-add
// or restoring-subtract step per cycle for WIDTH cycles.
module multicycle_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor
  logic [WIDTH-1:0] acc_q, acc_d;     // upper product / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier / dividend, becomes low product / quotient
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry;
  logic             is_multi;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic             is_div;

  // Single-cycle results straight from the input operands (used on accept).
  always_comb begin
    add_w     = {1'b0, op_a} + {1'b0, op_b};
    sub_w     = {1'b0, op_a} - {1'b0, op_b};
    sc_result = {1'b1, {(WIDTH-1){1'b0}}};
    sc_carry  = 1'b0;
    is_multi  = 1'b0;
    case (alu_sel)
      4'd0: begin
        sc_result = add_w[WIDTH-1:0];
        sc_carry  = add_w[WIDTH];
      end
      4'd1: begin
        sc_result = sub_w[WIDTH-1:0];
        sc_carry  = sub_w[WIDTH];          // top bit of the extended difference is the borrow
      end
      4'd2, 4'd3, 4'd6, 4'd7: is_multi = 1'b1;
      4'd4: begin
        sc_result = {op_a[WIDTH-2:0], 1'b0};
        sc_carry  = op_a[WIDTH-1];
      end
      4'd5: begin
        sc_result = {1'b0, op_a[WIDTH-1:1]};
        sc_carry  = op_a[0];
      end
      default: ;
    endcase
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    is_div    = (sel_q == 4'd3);
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // When div_ge holds the true difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  end

  // Next-state and datapath register updates for the IDLE/BUSY/DONE control.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    hi_d       = hi_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sel_d = alu_sel;
          if (is_multi) begin
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = BUSY;
            case (alu_sel)
              4'd2: begin opnd_d = op_a; lo_d = op_b; end
              4'd3: begin opnd_d = op_b; lo_d = op_a; end
              4'd6: begin opnd_d = op_a; lo_d = op_a; end
              default: begin opnd_d = op_b; lo_d = op_b; end
            endcase
          end else begin
            result_d   = sc_result;
            hi_d       = '0;
            carry_d    = sc_carry;
            zero_d     = (sc_result == '0);
            div_zero_d = 1'b0;
            state_d    = DONE;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (is_div) begin
            acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
        end else begin
          result_d   = lo_q;
          hi_d       = acc_q;
          zero_d     = (lo_q == '0);
          carry_d    = is_div ? 1'b0 : (acc_q != '0);
          div_zero_d = is_div && (opnd_q == '0);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      hi_q       <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      hi_q       <= hi_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign result_hi = hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign div_zero  = div_zero_q;

endmodule
